// File: rtl/cpu_pkg.sv
// Shared processor definitions: word size, stack geometry, controller opcodes
// and the decoded stack command set used by stack_unit.
package cpu_pkg;

    localparam int WORD_W      = 8;
    localparam int STACK_DEPTH = 16;

    // Controller opcodes (instruction encoding of the stack processor).
    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_PUSHI = 4'h1;
    localparam logic [3:0] OP_PUSHM = 4'h2;
    localparam logic [3:0] OP_POPM  = 4'h3;
    localparam logic [3:0] OP_ADD   = 4'h4;
    localparam logic [3:0] OP_SUB   = 4'h5;
    localparam logic [3:0] OP_AND   = 4'h6;
    localparam logic [3:0] OP_OR    = 4'h7;
    localparam logic [3:0] OP_DUP   = 4'h8;
    localparam logic [3:0] OP_SWAP  = 4'h9;
    localparam logic [3:0] OP_JMP   = 4'hA;
    localparam logic [3:0] OP_JZ    = 4'hB;

    // One resolved stack action per cycle after strobe priority is applied.
    typedef enum logic [2:0] {
        CMD_IDLE,
        CMD_XCHG,     // push & pop, stack holds data: swap top with din
        CMD_PUSH_UF,  // push & pop on empty: pop dropped, push proceeds
        CMD_POP,
        CMD_RD_UF,    // pop or tos on empty
        CMD_TOS,
        CMD_PUSH,
        CMD_PUSH_OF   // push while full: write dropped
    } stack_cmd_e;

    // Resolve the raw strobes: pop beats tos, push with tos is a plain push.
    function automatic stack_cmd_e decode_cmd(input logic push, input logic pop,
                                              input logic tos, input logic empty,
                                              input logic full);
        stack_cmd_e cmd;
        cmd = CMD_IDLE;
        if (pop) begin
            if (push) cmd = empty ? CMD_PUSH_UF : CMD_XCHG;
            else      cmd = empty ? CMD_RD_UF   : CMD_POP;
        end else if (push) begin
            cmd = full ? CMD_PUSH_OF : CMD_PUSH;
        end else if (tos) begin
            cmd = empty ? CMD_RD_UF : CMD_TOS;
        end
        return cmd;
    endfunction

endpackage

// File: rtl/stack_ram.sv
// Stack storage: DEPTH x WIDTH register array, one synchronous write port and
// one combinational read port.
module stack_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port; data becomes readable right after the edge that writes it.
    // NOTE: the array has no reset so it maps onto plain flops/RAM without a
    // reset tree; the stack pointer alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stack_unit.sv
// Operand stack: pointer, command decode, registered dout and sticky
// overflow/underflow flags around a stack_ram instance.
module stack_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = STACK_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       tos,
    input  logic [WIDTH-1:0]           din,
    input  logic                       clr_err,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [PW-1:0]    sp_q, sp_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    stack_cmd_e       cmd;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [AW-1:0]    top_addr;
    logic [WIDTH-1:0] rd_data;

    assign full     = (sp_q == PW'(DEPTH));
    assign empty    = (sp_q == '0);
    // Low bits of sp minus one; at sp == DEPTH the low bits are 0 and wrap
    // to DEPTH-1, which is the correct top entry.
    assign top_addr = sp_q[AW-1:0] - AW'(1);

    stack_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (din),
        .raddr (top_addr),
        .rdata (rd_data)
    );

    // Next-state decode for pointer, dout, flags and the array write.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        cmd    = decode_cmd(push, pop, tos, empty, full);
        sp_d   = sp_q;
        dout_d = dout_q;
        ovf_d  = ovf_q & ~clr_err;
        unf_d  = unf_q & ~clr_err;
        we     = 1'b0;
        waddr  = sp_q[AW-1:0];
        case (cmd)
            CMD_XCHG: begin
                dout_d = rd_data;
                we     = 1'b1;
                waddr  = top_addr;
            end
            CMD_PUSH_UF: begin
                unf_d = 1'b1;
                we    = 1'b1;
                waddr = '0;
                sp_d  = PW'(1);
            end
            CMD_POP: begin
                dout_d = rd_data;
                sp_d   = sp_q - PW'(1);
            end
            CMD_RD_UF:   unf_d  = 1'b1;
            CMD_TOS:     dout_d = rd_data;
            CMD_PUSH: begin
                we   = 1'b1;
                sp_d = sp_q + PW'(1);
            end
            CMD_PUSH_OF: ovf_d  = 1'b1;
            default: ;
        endcase
    end

    // State registers with asynchronous active-low reset.
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values sampled before the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp_q   <= '0;
            dout_q <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            sp_q   <= sp_d;
            dout_q <= dout_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    assign dout      = dout_q;
    assign count     = sp_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule
